// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C request arbiter
//
// Purpose : arbiter state encoding, I2C field widths and the requester-count ceiling.
// Ports   : none (package).

package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int I2C_ADDR_W  = 7;
  localparam int I2C_DATA_W  = 8;
  localparam int NUM_REQ_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority one-hot picker
//
// Purpose : choose one requester, searching upward from the slot after the last grant.
// Ports   : i_req      requester level vector
//           i_last_gnt index of the previous grant
//           o_gnt      one-hot pick (all zero when nothing requests)
//           o_idx      encoded pick index

module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_gnt,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  int   w_pos;
  logic w_found;

  // The slot just granted is visited last, so a held request falls to lowest priority.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = (int'(i_last_gnt) + k) % NUM_REQ;
      if (!w_found && ((i_req & (NUM_REQ'(1) << w_pos)) != '0)) begin
        w_found = 1'b1;
        o_gnt   = NUM_REQ'(1) << w_pos;
        o_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter and sequencer for one shared I2C master
//
// Purpose : grant one requester at a time, latch its payload, run the master's
//           enable/ready handshake so each transfer ends with a STOP, return the result.
// Option  : I2C_ARB_TIMEOUT_EN adds a per-phase cycle limit that aborts with rsp_err.
// Ports   : clk, rst (async, active-low)
//           req/req_addr/req_data/req_rw  requester side, packed per slot
//           gnt, done, rsp_data, rsp_err  responses to the granted requester
//           m_addr/m_data_in/m_rw/m_enable to the master; m_data_out/m_ready from it

module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_rw,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_data_in,
  output logic                          m_rw,
  output logic                          m_enable,
  input  logic [I2C_DATA_W-1:0]         m_data_out,
  input  logic                          m_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || TIMEOUT_CYC < 16) begin : g_bad_cfg
    $error("i2c_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 16");
  end

  arb_state_t              r_state;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      r_done;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_last_gnt;
  logic [I2C_ADDR_W-1:0]   r_m_addr;
  logic [I2C_DATA_W-1:0]   r_m_data_in;
  logic                    r_m_rw;
  logic                    r_m_enable;
  logic [I2C_DATA_W-1:0]   r_rsp_data;

  logic [NUM_REQ-1:0]      w_pick_gnt;
  logic [IDX_W-1:0]        w_pick_idx;
  logic [I2C_ADDR_W-1:0]   w_sel_addr;
  logic [I2C_DATA_W-1:0]   w_sel_data;
  logic                    w_sel_rw;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req      (req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_pick_gnt),
    .o_idx      (w_pick_idx)
  );

  // Payload mux for the slot the picker selected this cycle.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_rw   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        w_sel_data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
        w_sel_rw   = req_rw[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_idx       <= '0;
      r_last_gnt  <= IDX_W'(NUM_REQ - 1);
      r_m_addr    <= '0;
      r_m_data_in <= '0;
      r_m_rw      <= 1'b0;
      r_m_enable  <= 1'b0;
      r_rsp_data  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          // m_ready also gates a new grant after a timeout left the master busy.
          if (m_ready && (|req)) begin
            r_gnt       <= w_pick_gnt;
            r_idx       <= w_pick_idx;
            r_m_addr    <= w_sel_addr;
            r_m_data_in <= w_sel_data;
            r_m_rw      <= w_sel_rw;
            r_m_enable  <= 1'b1;
            r_state     <= ST_ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          // Dropping enable once the master leaves idle steers it to STOP after the byte.
          if (!m_ready) begin
            r_m_enable <= 1'b0;
            r_state    <= ST_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
            r_cnt      <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_m_enable <= 1'b0;
            r_done     <= r_gnt;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
`endif
          end
        end
        ST_BUSY: begin
          if (m_ready) begin
            r_done  <= r_gnt;
            r_state <= ST_DONE;
            if (r_m_rw) begin
              r_rsp_data <= m_data_out;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            r_rsp_err <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_done    <= r_gnt;
            r_rsp_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          r_gnt      <= '0;
          r_last_gnt <= r_idx;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rsp_data  = r_rsp_data;
  assign m_addr    = r_m_addr;
  assign m_data_in = r_m_data_in;
  assign m_rw      = r_m_rw;
  assign m_enable  = r_m_enable;

endmodule
